// File: rtl/pipeline_pkg.sv
// Shared types for the fetch stage: fetch FSM states, the bubble instruction and the IF/ID bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_fetch_if.sv
// Bundles the instruction-memory handshake, decode control and IF/ID outputs of the fetch stage.
// Latency: n/a (wires only).
// Backpressure: imem side is req/ack; decode side is Stall.
// master = fetch stage, slave = surrounding pipeline/memory (or a testbench).
interface ifid_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] InPC;
    logic [31:0] Inst;
    logic        InstValid;

    modport master (
        output imem_req, imem_addr, InPC, Inst, InstValid,
        input  imem_ack, imem_rdata, Stall, BranchTaken, BranchTarget
    );

    modport slave (
        input  imem_req, imem_addr, InPC, Inst, InstValid,
        output imem_ack, imem_rdata, Stall, BranchTaken, BranchTarget
    );
endinterface

// File: rtl/ifid_skid.sv
// One-entry skid buffer holding a fetched word that decode could not take.
// Latency: one cycle from load to visible entry.
// Backpressure: none; caller loads only while empty and drains when decode is free.
// Ports: CLK/RSTN, load/drain/clear strobes, load_dat in, entry_dat out (valid=0 when empty).
module ifid_skid
    import pipeline_pkg::*;
(
    input  logic  CLK,
    input  logic  RSTN,
    input  logic  load,
    input  logic  drain,
    input  logic  clear,
    input  ifid_t load_dat,
    output ifid_t entry_dat
);

    ifid_t entry_q;

    // clear wins over load so a redirect in the same cycle as a stalled ack
    // never leaves a wrong-path word behind
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            entry_q <= '0;
        end else if (clear || drain) begin
            entry_q <= '0;
        end else if (load) begin
            entry_q <= load_dat;
        end
    end

    assign entry_dat = entry_q;

endmodule

// File: rtl/ifid_fetch.sv
// Instruction fetch stage with PC, imem req/ack handshake and the IF/ID pipeline register.
// Latency: fetched word appears in IF/ID the cycle after its ack; one instruction per cycle at zero wait.
// Backpressure: Stall freezes IF/ID; a word acked under Stall parks in the skid buffer and fetch pauses.
// Ports: CLK, RSTN, bus (master modport: imem_req/addr/ack/rdata, Stall, BranchTaken/Target, InPC/Inst/InstValid).
module ifid_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = pipeline_pkg::NOP_INST
) (
    input  logic          CLK,
    input  logic          RSTN,
    ifid_fetch_if.master  bus
);
    import pipeline_pkg::*;

    fetch_state_t state_q;
    fetch_state_t state_nxt;
    logic [31:0]  pc_q;
    logic [31:0]  drop_addr_q;
    ifid_t        ifid_q;
    ifid_t        skid_dat;
    ifid_t        fetched_dat;
    logic         ack_vld;
    logic         skid_load;
    logic         skid_drain;
    logic [31:0]  target_addr;

    // ack only means something while a request is outstanding
    assign ack_vld     = bus.imem_ack && bus.imem_req;
    assign target_addr = word_align(bus.BranchTarget);
    assign fetched_dat = '{pc: pc_q, inst: bus.imem_rdata, valid: 1'b1};
    assign skid_load   = (state_q == FETCH) && ack_vld && bus.Stall && !bus.BranchTaken;
    assign skid_drain  = (state_q == HOLD) && !bus.Stall && !bus.BranchTaken;

    ifid_skid u_skid (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (bus.BranchTaken),
        .load_dat  (fetched_dat),
        .entry_dat (skid_dat)
    );

    // ---- FSM: state register ----
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (bus.BranchTaken) begin
                    // an unanswered request must still be completed, so park in DROP
                    state_nxt = ack_vld ? FETCH : DROP;
                end else if (ack_vld && bus.Stall) begin
                    state_nxt = HOLD;
                end
            end
            HOLD:  if (bus.BranchTaken || !bus.Stall) state_nxt = FETCH;
            // a further redirect here only moves the PC; the old request still owns the bus
            DROP:  if (ack_vld) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.imem_addr = pc_q;
        case (state_q)
            FETCH: bus.imem_req = 1'b1;
            DROP: begin
                bus.imem_req  = 1'b1;
                bus.imem_addr = drop_addr_q;
            end
            default: ;
        endcase
    end

    // ---- PC and abandoned-request address ----
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pc_q        <= word_align(RESET_PC);
            drop_addr_q <= '0;
        end else begin
            if (bus.BranchTaken) begin
                pc_q <= target_addr;
            end else if ((state_q == FETCH) && ack_vld) begin
                pc_q <= pc_q + 32'd4;
            end
            if ((state_q == FETCH) && bus.BranchTaken && !ack_vld) begin
                drop_addr_q <= pc_q;
            end
        end
    end

    // ---- IF/ID register ----
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ifid_q <= '{pc: 32'd0, inst: NOP_INST, valid: 1'b0};
        end else if (bus.BranchTaken) begin
            ifid_q.inst  <= NOP_INST;
            ifid_q.valid <= 1'b0;
        end else if (!bus.Stall) begin
            if (state_q == HOLD) begin
                ifid_q <= skid_dat;
            end else if ((state_q == FETCH) && ack_vld) begin
                ifid_q <= fetched_dat;
            end else begin
                // bubble; InPC keeps the last real PC
                ifid_q.inst  <= NOP_INST;
                ifid_q.valid <= 1'b0;
            end
        end
    end

    assign bus.InPC      = ifid_q.pc;
    assign bus.Inst      = ifid_q.inst;
    assign bus.InstValid = ifid_q.valid;

endmodule

// File: tb/tb_ifid_fetch.sv
// Testbench for ifid_fetch: directed scenarios plus randomized stall/redirect/memory-latency traffic.
// Latency: n/a.
// Backpressure: memory model inserts 0..2 wait cycles per request; Stall driven randomly.
module tb_ifid_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic CLK = 1'b0;
    logic RSTN;

    ifid_fetch_if bus ();

    ifid_fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  sb_e;
    int    checks  = 0;
    int    errors  = 0;
    int    sb_pops = 0;

    int    mem_wait = 0;     // <0 selects random 0..2 wait cycles
    bit    mem_busy = 1'b0;
    bit    mem_new  = 1'b0;
    int    mem_left = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hAAAA_AABA;
    endfunction

    // After reset or a redirect, decode must accept exactly the sequential
    // program stream starting at the (aligned) start address.
    task automatic restart_stream(input logic [31:0] start);
        logic [31:0] p;
        p = start & ~32'd3;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back('{pc: p, inst: mem_word(p)});
            p = p + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    // Instruction memory: answers each request after a chosen number of wait cycles.
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        forever begin
            @(posedge CLK);
            #1;
            mem_new = 1'b0;
            if (bus.imem_req) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_new  = 1'b1;
                    mem_left = (mem_wait < 0) ? int'($urandom_range(0, 2)) : mem_wait;
                end
                if (mem_left == 0) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = mem_word(bus.imem_addr);
                    mem_busy       = 1'b0;
                end else begin
                    bus.imem_ack   = 1'b0;
                    bus.imem_rdata = 32'hDEAD_BEEF;
                    mem_left--;
                end
            end else begin
                bus.imem_ack = 1'b0;
                mem_busy     = 1'b0;
            end
        end
    end

    task automatic wait_new_req(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge CLK);
            #2;
            if (mem_new && bus.imem_req && !bus.imem_ack) found = 1'b1;
        end
        chk1(name, found, 1'b1);
    endtask

    initial begin
        logic [31:0] old_addr;
        logic [31:0] t;
        bit          found;
        int          since;

        RSTN             = 1'b0;
        bus.Stall        = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = 32'h0;
        restart_stream(RESET_PC);

        // Scoreboard monitor: every instruction decode accepts must be next in program order.
        fork
            forever begin
                @(negedge CLK);
                if (RSTN && bus.InstValid && !bus.Stall && !bus.BranchTaken) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_underflow: accepted pc=%h inst=%h with nothing expected", bus.InPC, bus.Inst);
                    end else begin
                        sb_e = exp_q.pop_front();
                        sb_pops++;
                        if (bus.InPC !== sb_e.pc || bus.Inst !== sb_e.inst) begin
                            errors++;
                            $display("FAIL sb_inst: got pc=%h inst=%h, want pc=%h inst=%h",
                                     bus.InPC, bus.Inst, sb_e.pc, sb_e.inst);
                        end
                    end
                end
            end
        join_none

        // ---- reset values ----
        #12;
        chk1("rst_req", bus.imem_req, 1'b0);
        chk("rst_inpc", bus.InPC, 32'h0);
        chk("rst_inst", bus.Inst, NOP);
        chk1("rst_valid", bus.InstValid, 1'b0);

        // ---- zero-wait streaming from reset ----
        mem_wait = 0;
        @(posedge CLK);
        #2;
        RSTN = 1'b1;
        @(negedge CLK);
        chk1("idle_req", bus.imem_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("seq_addr", bus.imem_addr, 32'(4 * i));
            chk1("seq_req", bus.imem_req, 1'b1);
            if (i == 0) begin
                chk1("seq_first_valid", bus.InstValid, 1'b0);
            end else begin
                chk("seq_inpc", bus.InPC, 32'(4 * (i - 1)));
                chk("seq_inst", bus.Inst, mem_word(32'(4 * (i - 1))));
                chk1("seq_valid", bus.InstValid, 1'b1);
            end
        end

        // ---- stall while the word at 0x10 is acked ----
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge CLK);
            #2;
            if (bus.imem_req && bus.imem_addr == 32'h10) found = 1'b1;
        end
        chk1("sync_0x10", found, 1'b1);
        bus.Stall = 1'b1;
        @(negedge CLK);
        chk1("stall_ack_req", bus.imem_req, 1'b1);
        repeat (2) begin
            @(posedge CLK);
            #2;
            @(negedge CLK);
            chk1("stall_req_drop", bus.imem_req, 1'b0);
            chk("stall_hold_pc", bus.InPC, 32'h0C);
            chk("stall_hold_inst", bus.Inst, mem_word(32'h0C));
        end
        @(posedge CLK);
        #2;
        bus.Stall = 1'b0;
        @(negedge CLK);
        chk("unstall_old_pc", bus.InPC, 32'h0C);
        @(negedge CLK);
        chk("skid_addr", bus.imem_addr, 32'h14);
        chk("skid_inpc", bus.InPC, 32'h10);
        chk("skid_inst", bus.Inst, 32'hAAAA_AAAA);
        chk1("skid_valid", bus.InstValid, 1'b1);

        // ---- redirect in the same cycle as an ack ----
        @(posedge CLK);
        #2;
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'h103;
        restart_stream(32'h103);
        @(posedge CLK);
        #2;
        bus.BranchTaken = 1'b0;
        @(negedge CLK);
        chk("br_ack_addr", bus.imem_addr, 32'h100);
        chk("br_ack_inst", bus.Inst, NOP);
        chk1("br_ack_valid", bus.InstValid, 1'b0);

        // ---- redirect while the ack is two cycles late ----
        mem_wait = 2;
        wait_new_req("sync_late_req");
        old_addr         = bus.imem_addr;
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'h200;
        restart_stream(32'h200);
        @(posedge CLK);
        #2;
        bus.BranchTaken = 1'b0;
        @(negedge CLK);
        chk1("drop_req", bus.imem_req, 1'b1);
        chk("drop_addr_hold1", bus.imem_addr, old_addr);
        chk1("drop_valid1", bus.InstValid, 1'b0);
        @(negedge CLK);
        chk("drop_addr_hold2", bus.imem_addr, old_addr);
        @(negedge CLK);
        chk("drop_target_addr", bus.imem_addr, 32'h200);
        chk1("drop_no_stale", bus.InstValid, 1'b0);

        // ---- PC wrap ----
        mem_wait = 0;
        @(posedge CLK);
        #2;
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'hFFFF_FFF4;
        restart_stream(32'hFFFF_FFF4);
        @(posedge CLK);
        #2;
        bus.BranchTaken = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge CLK);
            #2;
            if (bus.imem_req && bus.imem_addr == 32'hFFFF_FFFC) found = 1'b1;
        end
        chk1("sync_wrap", found, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        chk("wrap_addr", bus.imem_addr, 32'h0);

        // ---- reset asserted in DROP ----
        mem_wait = 2;
        wait_new_req("sync_drop_rst");
        bus.BranchTaken  = 1'b1;
        bus.BranchTarget = 32'h300;
        restart_stream(32'h300);
        @(posedge CLK);
        #2;
        bus.BranchTaken = 1'b0;
        RSTN = 1'b0;
        #1;
        chk1("mid_rst_req", bus.imem_req, 1'b0);
        chk("mid_rst_inpc", bus.InPC, 32'h0);
        chk("mid_rst_inst", bus.Inst, NOP);
        chk1("mid_rst_valid", bus.InstValid, 1'b0);
        restart_stream(RESET_PC);
        mem_wait = 0;
        @(posedge CLK);
        #2;
        RSTN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk1("restart_req", bus.imem_req, 1'b1);
        chk("restart_addr", bus.imem_addr, RESET_PC);

        // ---- randomized traffic ----
        mem_wait = -1;
        since    = 0;
        sb_pops  = 0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge CLK);
            #2;
            bus.Stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0 || since > 80) begin
                if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else t = $urandom;
                bus.BranchTaken  = 1'b1;
                bus.BranchTarget = t;
                restart_stream(t);
                since = 0;
            end else begin
                bus.BranchTaken = 1'b0;
                since++;
            end
        end
        @(posedge CLK);
        #2;
        bus.Stall       = 1'b0;
        bus.BranchTaken = 1'b0;
        repeat (5) @(posedge CLK);
        chk1("sb_progress", sb_pops >= 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
